// File: rtl/polynomial_finder_scheduler_if.sv
// polynomial_finder_scheduler_if: channel request/result bus plus shared finder operand/handshake signals.
interface polynomial_finder_scheduler_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0] req, done;
  logic [24*NUM_CH-1:0] ts_last_data_bus, ts_last_data1_bus;
  logic [17*NUM_CH-1:0] decoded_data_bus, decoded_data1_bus;
  logic result_valid, result_timeout, busy, finder_enable, finder_ready;
  logic [2:0] result_channel;
  logic [16:0] result_polynomial, result_iteration;
  logic [23:0] finder_ts_last_data, finder_ts_last_data1;
  logic [16:0] finder_decoded_data, finder_decoded_data1;
  logic [16:0] finder_polynomial, finder_iteration_number;
  modport master (
    input req, ts_last_data_bus, ts_last_data1_bus, decoded_data_bus, decoded_data1_bus,
    input finder_polynomial, finder_iteration_number, finder_ready,
    output done, result_valid, result_channel, result_polynomial, result_iteration, result_timeout, busy,
    output finder_enable, finder_ts_last_data, finder_ts_last_data1, finder_decoded_data, finder_decoded_data1
  );
  modport slave (
    output req, ts_last_data_bus, ts_last_data1_bus, decoded_data_bus, decoded_data1_bus,
    output finder_polynomial, finder_iteration_number, finder_ready,
    input done, result_valid, result_channel, result_polynomial, result_iteration, result_timeout, busy,
    input finder_enable, finder_ts_last_data, finder_ts_last_data1, finder_decoded_data, finder_decoded_data1
  );
endinterface

// File: rtl/polynomial_finder_scheduler.sv
// polynomial_finder_scheduler: round-robin sharing of one polynomial_finder between NUM_CH channels.
module polynomial_finder_scheduler #(
  parameter int NUM_CH = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DRAIN_CYCLES = 2
) (
  input logic clk_96MHz,
  input logic reset,
  polynomial_finder_scheduler_if.master bus
);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [2:0] last_grant_q, last_grant_d, rch_q, rch_d, grant;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [23:0] ts_q, ts_d, ts1_q, ts1_d;
  logic [16:0] dd_q, dd_d, dd1_q, dd1_d, poly_q, poly_d, iter_q, iter_d;
  logic [NUM_CH-1:0] done_q, done_d, rot;
  logic en_q, en_d, valid_q, valid_d, tmo_q, tmo_d, busy_q, hit_ready, tmo_hit;
  logic [3:0] off, sum;
  // Rotate requests so bit 0 is the channel right after last_grant; lowest set bit wins.
  always_comb begin
    rot = NUM_CH'({bus.req, bus.req} >> (4'(last_grant_q) + 4'd1));
    off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) off = rot[i] ? 4'(i) : off;
    sum = 4'(last_grant_q) + 4'd1 + off;
    grant = (sum >= 4'(NUM_CH)) ? 3'(sum - 4'(NUM_CH)) : 3'(sum);
  end
  assign hit_ready = (state_q == WAIT_DONE) && bus.finder_ready;
  assign tmo_hit = cnt_q >= TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    rch_d = rch_q;
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    drain_d = drain_q + 1'b1;
    en_d = en_q;
    ts_d = ts_q;
    ts1_d = ts1_q;
    dd_d = dd_q;
    dd1_d = dd1_q;
    poly_d = poly_q;
    iter_d = iter_q;
    tmo_d = tmo_q;
    done_d = '0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = WAIT_START;
        last_grant_d = grant;
        en_d = 1'b1;
        cnt_d = '0;
        ts_d = bus.ts_last_data_bus[24*grant +: 24];
        ts1_d = bus.ts_last_data1_bus[24*grant +: 24];
        dd_d = bus.decoded_data_bus[17*grant +: 17];
        dd1_d = bus.decoded_data1_bus[17*grant +: 17];
      end
      WAIT_START, WAIT_DONE: if (hit_ready || tmo_hit) begin
        state_d = DRAIN;
        drain_d = '0;
        en_d = 1'b0;
        valid_d = 1'b1;
        done_d = NUM_CH'(1) << last_grant_q;
        rch_d = last_grant_q;
        tmo_d = !hit_ready;
        poly_d = hit_ready ? bus.finder_polynomial : '0;
        iter_d = hit_ready ? bus.finder_iteration_number : '0;
      end else if (state_q == WAIT_START && !bus.finder_ready) state_d = WAIT_DONE;
      default: state_d = (drain_q == DW'(DRAIN_CYCLES - 1)) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk_96MHz)
    if (reset) begin
      state_q <= IDLE;
      last_grant_q <= 3'(NUM_CH - 1);
      rch_q <= '0;
      cnt_q <= '0;
      drain_q <= '0;
      en_q <= 1'b0;
      ts_q <= '0;
      ts1_q <= '0;
      dd_q <= '0;
      dd1_q <= '0;
      poly_q <= '0;
      iter_q <= '0;
      tmo_q <= 1'b0;
      done_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      rch_q <= rch_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      en_q <= en_d;
      ts_q <= ts_d;
      ts1_q <= ts1_d;
      dd_q <= dd_d;
      dd1_q <= dd1_d;
      poly_q <= poly_d;
      iter_q <= iter_d;
      tmo_q <= tmo_d;
      done_q <= done_d;
      valid_q <= valid_d;
      busy_q <= state_d != IDLE;
    end
  assign bus.done = done_q;
  assign bus.result_valid = valid_q;
  assign bus.result_channel = rch_q;
  assign bus.result_polynomial = poly_q;
  assign bus.result_iteration = iter_q;
  assign bus.result_timeout = tmo_q;
  assign bus.busy = busy_q;
  assign bus.finder_enable = en_q;
  assign bus.finder_ts_last_data = ts_q;
  assign bus.finder_ts_last_data1 = ts1_q;
  assign bus.finder_decoded_data = dd_q;
  assign bus.finder_decoded_data1 = dd1_q;
endmodule

// File: tb/tb_polynomial_finder_scheduler.sv
// tb_polynomial_finder_scheduler: scoreboard bench with a behavioural finder model.
module tb_polynomial_finder_scheduler;
  localparam int NUM_CH = 4;
  localparam int TMO = 64;
  localparam logic [16:0] PA = 17'h1d258;
  localparam logic [16:0] PB = 17'h17e04;
  logic clk = 1'b0;
  logic reset;
  polynomial_finder_scheduler_if #(.NUM_CH(NUM_CH)) bus();
  polynomial_finder_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TMO), .DRAIN_CYCLES(2)) dut (
    .clk_96MHz(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] ch;
    logic [16:0] dd, poly, iter;
    logic tmo;
    int lat_max;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_res = 0, cyc = 0, grant_cyc = 0, low_cnt = 99;
  logic [16:0] ch_dd[NUM_CH], ch_poly[NUM_CH];
  int ch_iter[NUM_CH], ch_lat[NUM_CH];
  logic hang = 1'b0, rst_edge = 1'b1, en_prev = 1'b0;
  logic [81:0] ops_prev = '0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [16:0] lfsr(logic [16:0] x, logic [16:0] p);
    return x[0] ? ((x >> 1) ^ p) : (x >> 1);
  endfunction
  function automatic logic [16:0] walk(logic [16:0] x, logic [16:0] p, int k);
    for (int i = 0; i < k; i++) x = lfsr(x, p);
    return x;
  endfunction
  task automatic set_ch(int c, logic [16:0] d, int k, logic [16:0] p, logic [23:0] t);
    bus.decoded_data_bus[17*c +: 17] = d;
    bus.decoded_data1_bus[17*c +: 17] = walk(d, p, k);
    bus.ts_last_data_bus[24*c +: 24] = t;
    bus.ts_last_data1_bus[24*c +: 24] = t + 24'(16 * k);
    ch_dd[c] = d;
    ch_poly[c] = (k == 0) ? 17'h0 : p;
    ch_iter[c] = k;
    ch_lat[c] = (k == 0) ? 10 : 0;
  endtask
  task automatic push(int c, logic tmo);
    q.push_back('{ch: 3'(c), dd: ch_dd[c], poly: tmo ? 17'h0 : ch_poly[c],
                  iter: tmo ? 17'h0 : 17'(ch_iter[c]), tmo: tmo, lat_max: tmo ? 0 : ch_lat[c]});
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_res(int target, int budget);
    for (int t = 0; t < budget && n_res < target; t++) step(1);
    if (n_res < target) chk("result_wait", n_res, target);
  endtask
  task automatic wait_en();
    for (int t = 0; t < 50 && !bus.finder_enable; t++) step(1);
    if (!bus.finder_enable) chk("grant_wait", bus.finder_enable, 1);
  endtask
  // Finder model: drops ready once enabled, walks both LFSRs one step per cycle.
  logic fm_busy = 1'b0, fm_done = 1'b0;
  logic [16:0] xa, xb;
  int fk;
  always @(posedge clk) begin
    if (!bus.finder_enable) begin
      bus.finder_ready <= 1'b1;
      fm_busy <= 1'b0;
      fm_done <= 1'b0;
    end else if (!fm_busy && !fm_done) begin
      fm_busy <= 1'b1;
      bus.finder_ready <= 1'b0;
      xa <= bus.finder_decoded_data;
      xb <= bus.finder_decoded_data;
      fk <= 0;
    end else if (fm_busy && !hang) begin
      if (bus.finder_decoded_data == bus.finder_decoded_data1 || fk == 60 ||
          lfsr(xa, PA) == bus.finder_decoded_data1 || lfsr(xb, PB) == bus.finder_decoded_data1) begin
        bus.finder_ready <= 1'b1;
        fm_busy <= 1'b0;
        fm_done <= 1'b1;
        bus.finder_polynomial <= (bus.finder_decoded_data == bus.finder_decoded_data1 || fk == 60) ? 17'h0 :
                                 (lfsr(xa, PA) == bus.finder_decoded_data1) ? PA : PB;
        bus.finder_iteration_number <= (bus.finder_decoded_data == bus.finder_decoded_data1 || fk == 60) ? 17'h0 : 17'(fk + 1);
      end else begin
        xa <= lfsr(xa, PA);
        xb <= lfsr(xb, PB);
        fk <= fk + 1;
      end
    end
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edge <= reset;
  end
  always @(negedge clk) begin
    logic [81:0] ops;
    logic rise;
    exp_t e;
    ops = {bus.finder_ts_last_data, bus.finder_ts_last_data1, bus.finder_decoded_data, bus.finder_decoded_data1};
    rise = bus.finder_enable && !en_prev;
    if (!rst_edge && ops != ops_prev) chk("ops_only_on_grant", rise, 1);
    if (rise) begin
      grant_cyc = cyc;
      chk("en_low_gap", low_cnt >= 2, 1);
      chk("busy_grant", bus.busy, 1);
      if (q.size() > 0) chk("grant_operand", bus.finder_decoded_data, q[0].dd);
    end
    low_cnt = rst_edge ? 99 : (bus.finder_enable ? 0 : low_cnt + 1);
    if (|bus.done || bus.result_valid) chk("done_vs_valid", |bus.done, bus.result_valid);
    if (bus.result_valid) begin
      n_res++;
      if (q.size() == 0) chk("extra_result", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("channel", bus.result_channel, e.ch);
        chk("done_onehot", bus.done, 4'b1 << e.ch);
        chk("polynomial", bus.result_polynomial, e.poly);
        chk("iteration", bus.result_iteration, e.iter);
        chk("timeout_flag", bus.result_timeout, e.tmo);
        chk("en_low_at_result", bus.finder_enable, 0);
        if (e.tmo) chk("timeout_latency", cyc - grant_cyc, TMO);
        if (e.lat_max > 0) chk("fast_latency", (cyc - grant_cyc) <= e.lat_max, 1);
      end
    end
    en_prev = bus.finder_enable;
    ops_prev = ops;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.req = '0;
    set_ch(0, 17'h01111, 3, PA, 24'h000100);
    set_ch(1, 17'h02222, 5, PB, 24'h000200);
    set_ch(2, 17'h05555, 4, PA, 24'h000300);
    set_ch(3, 17'h03333, 7, PA, 24'h000400);
    bus.req = 4'b1011;
    step(3);
    chk("rst_enable", bus.finder_enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_channel", bus.result_channel, 0);
    chk("rst_poly", bus.result_polynomial, 0);
    chk("rst_iter", bus.result_iteration, 0);
    chk("rst_tmo", bus.result_timeout, 0);
    chk("rst_operand", bus.finder_decoded_data, 0);
    chk("rst_ts", bus.finder_ts_last_data1, 0);
    for (int r = 0; r < 2; r++) begin
      push(0, 0);
      push(1, 0);
      push(3, 0);
    end
    reset = 1'b0;
    wait_res(6, 400);
    bus.req = '0;
    step(5);
    set_ch(0, 17'h0beef, 0, PA, 24'h000800);
    bus.req = 4'b0001;
    push(0, 0);
    wait_res(7, 60);
    bus.req = '0;
    step(5);
    set_ch(1, 17'h0abcd, 20, PA, 24'h001000);
    bus.req = 4'b0010;
    push(1, 0);
    wait_en();
    bus.req = '0;
    step(3);
    bus.req = 4'b0100;
    step(1);
    bus.req = '0;
    wait_res(8, 100);
    step(5);
    hang = 1'b1;
    set_ch(3, 17'h07777, 6, PB, 24'h002000);
    bus.req = 4'b0100;
    push(2, 1);
    push(3, 0);
    wait_en();
    bus.req = 4'b1000;
    wait_res(9, 200);
    hang = 1'b0;
    wait_res(10, 100);
    bus.req = '0;
    step(5);
    hang = 1'b1;
    bus.req = 4'b0010;
    wait_en();
    for (int t = 0; t < 20 && bus.finder_ready !== 1'b0; t++) step(1);
    chk("finder_started", bus.finder_ready, 0);
    step(6);
    bus.req = 4'b0011;
    reset = 1'b1;
    hang = 1'b0;
    push(0, 0);
    push(1, 0);
    step(1);
    chk("abort_enable", bus.finder_enable, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.result_valid, 0);
    reset = 1'b0;
    wait_res(12, 200);
    bus.req = '0;
    step(10);
    chk("queue_empty", q.size(), 0);
    chk("result_count", n_res, 12);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
